// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and counter width.
// Also used by hazard/stall control and the decoder.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit divider: quotient truncates toward zero, remainder follows the dividend's sign.
// Divide-by-zero is flagged and the datapath is kept X-free by substituting a divisor of 1.
module mdu_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  // Unsigned divide on magnitudes; 0x80000000 / -1 wraps naturally back to 0x80000000.
  always_comb begin
    neg_a     = is_signed & dividend[31];
    neg_b     = is_signed & divisor[31];
    mag_a     = neg_a ? -dividend : dividend;
    mag_b     = neg_b ? -divisor : divisor;
    div_zero  = (divisor == 32'd0);
    safe_b    = div_zero ? 32'd1 : mag_b;
    mag_q     = mag_a / safe_b;
    mag_r     = mag_a % safe_b;
    quotient  = (neg_a ^ neg_b) ? -mag_q : mag_q;
    remainder = neg_a ? -mag_r : mag_r;
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Define MDU_DIV_EN to compile in DIV/DIVU; otherwise they behave as no-ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_we;

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  // Sign-extend to 64 bits first so the low 64 bits of the product are the exact signed result.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

`ifdef MDU_DIV_EN
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_zero;

  mdu_divider u_divider (
    .dividend  (A),
    .divisor   (B),
    .is_signed (op == OP_DIV),
    .quotient  (div_q),
    .remainder (div_r),
    .div_zero  (div_zero)
  );
`endif

  // Results are captured at issue and only committed on the last busy edge, so a reset
  // mid-operation simply drops them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                pend_hi <= prod_s[63:32];
                pend_lo <= prod_s[31:0];
                pend_we <= 1'b1;
                count   <= CNT_W'(MUL_CYCLES);
                state   <= RUN;
                busy    <= 1'b1;
              end
              OP_MULTU: begin
                pend_hi <= prod_u[63:32];
                pend_lo <= prod_u[31:0];
                pend_we <= 1'b1;
                count   <= CNT_W'(MUL_CYCLES);
                state   <= RUN;
                busy    <= 1'b1;
              end
`ifdef MDU_DIV_EN
              OP_DIV, OP_DIVU: begin
                pend_hi <= div_r;
                pend_lo <= div_q;
                pend_we <= ~div_zero;
                count   <= CNT_W'(DIV_CYCLES);
                state   <= RUN;
                busy    <= 1'b1;
              end
`endif
              OP_MTHI: hi <= A;
              OP_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pend_we <= 1'b0;
            if (pend_we) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against an arithmetic reference model of HI/LO and busy length.
// Honors MDU_DIV_EN so the model matches whichever divider build is compiled.
module tb_mdu;

  localparam int MUL = 5;
  localparam int DIV = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          testsRun;
  int          testsFailed;
  logic [31:0] modelHi;
  logic [31:0] modelLo;

  mdu #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: what an issue of (code, a, b) should do, from plain arithmetic.
  task automatic modelOp(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
    logic [63:0] wide;
    logic [63:0] q;
    logic [63:0] r;
    cycles = 0;
    case (code)
      3'd0: begin
        wide = 64'(longint'($signed(a)) * longint'($signed(b)));
        modelHi = wide[63:32];
        modelLo = wide[31:0];
        cycles = MUL;
      end
      3'd1: begin
        wide = {32'd0, a} * {32'd0, b};
        modelHi = wide[63:32];
        modelLo = wide[31:0];
        cycles = MUL;
      end
      3'd2, 3'd3: begin
`ifdef MDU_DIV_EN
        cycles = DIV;
        if (b != 32'd0) begin
          if (code == 3'd2) begin
            q = 64'(longint'($signed(a)) / longint'($signed(b)));
            r = 64'(longint'($signed(a)) % longint'($signed(b)));
          end else begin
            q = {32'd0, a} / {32'd0, b};
            r = {32'd0, a} % {32'd0, b};
          end
          modelLo = q[31:0];
          modelHi = r[31:0];
        end
`endif
      end
      3'd4: modelHi = a;
      3'd5: modelLo = a;
      default: ;
    endcase
  endtask

  // Issue one op, optionally poke a stray start during busy cycle 2, then check busy length and HI/LO.
  task automatic applyStimulus(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                               input bit intrude);
    int   expCycles;
    int   seen;
    logic [31:0] oldHi;
    oldHi = modelHi;
    modelOp(code, a, b, expCycles);
    @(negedge clk);
    start = 1'b1;
    op    = code;
    A     = a;
    B     = b;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0 && expCycles > 0) checkOutput("hi held while busy", hi, oldHi);
      if (!busy) break;
      seen++;
      if (intrude && seen == 2) begin
        start = 1'b1;
        op    = 3'($urandom_range(0, 5));
        A     = $urandom;
        B     = $urandom;
      end
    end
    checkOutput("busy cycles", 32'(seen), 32'(expCycles));
    checkOutput("hi", hi, modelHi);
    checkOutput("lo", lo, modelLo);
  endtask

  initial begin
    int          dummy;
    logic [31:0] ra;
    logic [31:0] rb;
    testsRun    = 0;
    testsFailed = 0;
    modelHi     = '0;
    modelLo     = '0;
    start = 1'b0;
    op    = '0;
    A     = '0;
    B     = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset = 1'b1;

    applyStimulus(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    applyStimulus(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    applyStimulus(3'd3, 32'd7, 32'd2, 1'b0);
    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    applyStimulus(3'd4, 32'h00000011, 32'd0, 1'b0);
    applyStimulus(3'd5, 32'h00000022, 32'd0, 1'b0);
    applyStimulus(3'd3, 32'h12345678, 32'd0, 1'b0);
    applyStimulus(3'd4, 32'hABCD0000, 32'd0, 1'b0);
    applyStimulus(3'd6, 32'hDEADBEEF, 32'd1, 1'b0);
    applyStimulus(3'd0, 32'h00001234, 32'hFFFF0001, 1'b1);

    // Reset in the middle of a long operation must clear everything and never commit.
    applyStimulus(3'd4, 32'h0000AAAA, 32'd0, 1'b0);
`ifdef MDU_DIV_EN
    modelOp(3'd3, 32'd100, 32'd7, dummy);
    op = 3'd3;
`else
    modelOp(3'd0, 32'd100, 32'd7, dummy);
    op = 3'd0;
`endif
    @(negedge clk);
    start = 1'b1;
    A = 32'd100;
    B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midop reset busy", 32'(busy), 32'd0);
    checkOutput("midop reset hi", hi, 32'd0);
    checkOutput("midop reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    modelHi = '0;
    modelLo = '0;
    repeat (15) @(negedge clk);
    checkOutput("no late commit busy", 32'(busy), 32'd0);
    checkOutput("no late commit hi", hi, 32'd0);
    checkOutput("no late commit lo", lo, 32'd0);

    for (int n = 0; n < 80; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        default: ;
      endcase
      applyStimulus(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
